gpio_cfg_bank: RTL and testbench

// Generalised successor to per-register GPIO shift clocks: one serial frame protocol on the PS GPIO bus

---
 rtl/gpio_cfg_bank_pkg.sv | 25 ++
 rtl/gpio_edge_sync.sv | 32 +++
 rtl/gpio_cfg_bank.sv | 181 ++++++++++++++++++
 tb/tb_gpio_cfg_bank.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_bank_pkg.sv
// Shared constants for the GPIO configuration bank: PS GPIO line map, bus widths,
// frame address of the channel-select word and the commit FSM state type.
package gpio_cfg_bank_pkg;

  localparam int config_reg_width = 32;
  localparam int gpio_bus_width   = 32;

  localparam int cfg_sdata   = 16;
  localparam int cfg_sclk    = 17;
  localparam int cfg_latch   = 18;
  localparam int cfg_commit  = 19;
  localparam int cfg_err_clr = 20;

  localparam int cfg_addr_chan_sel = 0;

  typedef enum logic {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commit_state_t;

  function automatic int frame_len(input int addr_width, input int reg_width);
    return 1 + addr_width + reg_width;
  endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Synchroniser for one asynchronous GPIO line with rising-edge detect.
// Edges are suppressed until the chain has refilled after reset, so a line held high is not an edge.
module gpio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      prev_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = fill_q[SYNC_STAGES] & level & ~prev_q;

endmodule

// File: rtl/gpio_cfg_bank.sv
// Serial-frame configuration bank: double-buffered config words per channel, loaded over PS GPIO,
// with commit deferral while a run is active and serial readback of active words.
//   state          | meaning
//   COMMIT_IDLE    | no commit outstanding
//   COMMIT_PENDING | commit requested during a run; copy when run_active drops
module gpio_cfg_bank
  import gpio_cfg_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_REGS     = 8,
  parameter int REG_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int GPIO_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [GPIO_WIDTH-1:0]                      gpio_in,
  input  logic                                       run_active,
  output logic [NUM_CHANNELS*NUM_REGS*REG_WIDTH-1:0] cfg_q,
  output logic                                       cfg_update,
  output logic                                       commit_pend,
  output logic                                       frame_err,
  output logic                                       sdo
);

  localparam int FL    = frame_len(ADDR_WIDTH, REG_WIDTH);
  localparam int CW    = $clog2(FL + 2);
  localparam int CHW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int RIW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WORDS = NUM_CHANNELS * NUM_REGS;
  localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SEL_ADDR = ADDR_WIDTH'(cfg_addr_chan_sel);

  logic sdata_lvl, sclk_lvl, latch_lvl, commit_lvl, clr_lvl;
  logic sdata_rise, sclk_rise, latch_rise, commit_rise, clr_rise;

  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .line(gpio_in[cfg_sdata]), .level(sdata_lvl), .rise(sdata_rise));
  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .line(gpio_in[cfg_sclk]), .level(sclk_lvl), .rise(sclk_rise));
  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .rst_n(rst_n), .line(gpio_in[cfg_latch]), .level(latch_lvl), .rise(latch_rise));
  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_commit (
    .clk(clk), .rst_n(rst_n), .line(gpio_in[cfg_commit]), .level(commit_lvl), .rise(commit_rise));
  gpio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst_n(rst_n), .line(gpio_in[cfg_err_clr]), .level(clr_lvl), .rise(clr_rise));

  logic unused_lines;
  assign unused_lines = ^{gpio_in, sdata_rise, sclk_lvl, latch_lvl, commit_lvl, clr_lvl};

  logic [FL-1:0] shift_q, shift_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;

  // A latch edge decodes the shifter as it will be after any same-cycle shift.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (sclk_rise) begin
      shift_nxt = {shift_q[FL-2:0], sdata_lvl};
      if (cnt_q != CW'(FL + 1)) cnt_nxt = cnt_q + 1'b1;
    end
  end

  logic                  f_rd;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic [REG_WIDTH-1:0]  f_data;
  logic                  len_ok, addr_ok, err_set, sel_wr, wr_en, rd_load;
  logic [RIW-1:0]        reg_idx;

  assign f_rd    = shift_nxt[FL-1];
  assign f_addr  = shift_nxt[FL-2 -: ADDR_WIDTH];
  assign f_data  = shift_nxt[REG_WIDTH-1:0];
  assign len_ok  = (cnt_nxt == CW'(FL));
  assign addr_ok = (f_addr <= MAX_ADDR);
  assign err_set = latch_rise & (~len_ok | ~addr_ok);
  assign sel_wr  = latch_rise & len_ok & ~f_rd & (f_addr == SEL_ADDR);
  assign wr_en   = latch_rise & len_ok & addr_ok & ~f_rd & (f_addr != SEL_ADDR);
  assign rd_load = latch_rise & len_ok & f_rd;
  assign reg_idx = RIW'(f_addr - 1'b1);

  logic [NUM_CHANNELS-1:0] chan_sel;
  logic [CHW-1:0]          low_idx;
  logic [WIW-1:0]          word_idx;
  logic [REG_WIDTH-1:0]    active_words [WORDS];
  logic [REG_WIDTH-1:0]    rb_val, rb_q;

  always_comb begin
    low_idx = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (chan_sel[c]) low_idx = CHW'(c);
    end
  end

  assign word_idx = WIW'(low_idx) * WIW'(NUM_REGS) + WIW'(reg_idx);

  always_comb begin
    rb_val = '0;
    if (f_addr == SEL_ADDR) rb_val = REG_WIDTH'(chan_sel);
    else if (addr_ok && chan_sel != '0) rb_val = active_words[word_idx];
  end

  commit_state_t state;
  logic          copy;

  assign copy = (state == COMMIT_IDLE) ? (commit_rise & ~run_active) : ~run_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      chan_sel  <= '0;
      rb_q      <= '0;
      frame_err <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      cnt_q   <= latch_rise ? '0 : cnt_nxt;
      if (sel_wr) chan_sel <= f_data[NUM_CHANNELS-1:0];
      if (rd_load) rb_q <= rb_val;
      else if (sclk_rise) rb_q <= {rb_q[REG_WIDTH-2:0], 1'b0};
      if (err_set) frame_err <= 1'b1;
      else if (clr_rise) frame_err <= 1'b0;
    end
  end

  assign sdo = rb_q[REG_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COMMIT_IDLE;
      cfg_update  <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      cfg_update <= copy;
      case (state)
        COMMIT_IDLE: begin
          if (commit_rise && run_active) begin
            state       <= COMMIT_PENDING;
            commit_pend <= 1'b1;
          end
        end
        COMMIT_PENDING: begin
          if (!run_active) begin
            state       <= COMMIT_IDLE;
            commit_pend <= 1'b0;
          end
        end
        default: begin
          state       <= COMMIT_IDLE;
          commit_pend <= 1'b0;
        end
      endcase
    end
  end

  // Commit copies the post-write shadow so a same-cycle write is included.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic                 hit;
      logic [REG_WIDTH-1:0] shadow_q, shadow_nxt, active_q;

      assign hit        = wr_en & chan_sel[c] & (reg_idx == RIW'(r));
      assign shadow_nxt = hit ? f_data : shadow_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          shadow_q <= shadow_nxt;
          if (copy) active_q <= shadow_nxt;
        end
      end

      assign active_words[c*NUM_REGS + r]                  = active_q;
      assign cfg_q[(c*NUM_REGS + r)*REG_WIDTH +: REG_WIDTH] = active_q;
    end
  end

endmodule

// File: tb/tb_gpio_cfg_bank.sv
// Directed plus randomized bench for gpio_cfg_bank, checked against a word-level model
// of channel select, shadow/active banks, readback and the error flag.
module tb_gpio_cfg_bank;

  localparam int NC = 4, NR = 8, RW = 32, AW = 4, GW = 32, SS = 2, FL = 37;
  localparam int I_SDATA = 16, I_SCLK = 17, I_LATCH = 18, I_COMMIT = 19, I_CLR = 20;
  localparam logic [GW-1:0] M_LATCH  = 32'h1 << I_LATCH;
  localparam logic [GW-1:0] M_COMMIT = 32'h1 << I_COMMIT;
  localparam logic [GW-1:0] M_CLR    = 32'h1 << I_CLR;
  localparam logic [GW-1:0] M_USED   = 32'h001F_0000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [GW-1:0]        gpio_in;
  logic                 run_active;
  logic [NC*NR*RW-1:0]  cfg_q;
  logic                 cfg_update, commit_pend, frame_err, sdo;

  gpio_cfg_bank #(
    .NUM_CHANNELS(NC), .NUM_REGS(NR), .REG_WIDTH(RW),
    .ADDR_WIDTH(AW), .GPIO_WIDTH(GW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .run_active(run_active),
    .cfg_q(cfg_q), .cfg_update(cfg_update), .commit_pend(commit_pend),
    .frame_err(frame_err), .sdo(sdo)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int upd_seen = 0, upd_exp = 0;
  always @(negedge clk) if (cfg_update === 1'b1) upd_seen++;

  logic [RW-1:0] sh_m  [NC][NR];
  logic [RW-1:0] act_m [NC][NR];
  logic [NC-1:0] sel_m;
  logic [RW-1:0] rb_m;
  bit            err_m, pend_m;
  int            cnt_m;
  logic [63:0]   last_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) begin
        sh_m[c][r]  = '0;
        act_m[c][r] = '0;
      end
    sel_m = '0; rb_m = '0; err_m = 0; pend_m = 0; cnt_m = 0;
  endtask

  function automatic logic [FL-1:0] mk(input logic rd, input logic [AW-1:0] a, input logic [RW-1:0] d);
    return {rd, a, d};
  endfunction

  function automatic logic [RW-1:0] word(input int c, input int r);
    return cfg_q[(c*NR + r)*RW +: RW];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " frame_err"}, frame_err, err_m);
    chk({tag, " commit_pend"}, commit_pend, pend_m);
    chk({tag, " update_count"}, upd_seen, upd_exp);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        chk($sformatf("%s cfg_q c%0d r%0d", tag, c, r), word(c, r), act_m[c][r]);
  endtask

  task automatic pulse(input logic [GW-1:0] mask);
    gpio_in = gpio_in | mask;
    cycles(5);
    gpio_in = gpio_in & ~mask;
    cycles(5);
  endtask

  // Shift the first n bits of fr MSB first, sampling sdo before every sclk rise.
  task automatic send_bits(input logic [FL-1:0] fr, input int n);
    logic [63:0] cap, expv;
    cap = '0; expv = '0;
    for (int i = 0; i < n; i++) begin
      gpio_in[I_SDATA] = fr[FL-1-i];
      cycles(4);
      cap  = {cap[62:0], sdo};
      expv = {expv[62:0], (i < RW) ? rb_m[RW-1-i] : 1'b0};
      gpio_in[I_SCLK] = 1'b1;
      cycles(5);
      gpio_in[I_SCLK] = 1'b0;
      cycles(4);
    end
    gpio_in[I_SDATA] = 1'b0;
    chk("sdo_stream", cap, expv);
    last_cap = cap;
    rb_m  = (n >= RW) ? '0 : (rb_m << n);
    cnt_m = (cnt_m + n > FL + 1) ? FL + 1 : cnt_m + n;
  endtask

  task automatic model_commit();
    if (pend_m) return;
    if (run_active) pend_m = 1;
    else begin
      for (int c = 0; c < NC; c++)
        for (int r = 0; r < NR; r++) act_m[c][r] = sh_m[c][r];
      upd_exp++;
    end
  endtask

  task automatic model_latch(input logic [FL-1:0] fr, output bit e);
    logic          rd;
    int            addr, low;
    logic [RW-1:0] d;
    rd = fr[FL-1]; addr = int'(fr[FL-2 -: AW]); d = fr[RW-1:0];
    e = 0;
    low = -1;
    for (int c = NC - 1; c >= 0; c--) if (sel_m[c]) low = c;
    if (cnt_m != FL) e = 1;
    else if (addr > NR) begin
      e = 1;
      if (rd) rb_m = '0;
    end else if (rd) begin
      if (addr == 0) rb_m = RW'(sel_m);
      else if (low < 0) rb_m = '0;
      else rb_m = act_m[low][addr-1];
    end else if (addr == 0) sel_m = d[NC-1:0];
    else begin
      for (int c = 0; c < NC; c++) if (sel_m[c]) sh_m[c][addr-1] = d;
    end
    cnt_m = 0;
    if (e) err_m = 1;
  endtask

  task automatic latch(input logic [FL-1:0] fr, input logic [GW-1:0] also);
    bit e;
    model_latch(fr, e);
    if ((also & M_COMMIT) != 0) model_commit();
    if ((also & M_CLR) != 0 && !e) err_m = 0;
    pulse(M_LATCH | also);
  endtask

  task automatic frame(input logic [FL-1:0] fr, input logic [GW-1:0] also);
    send_bits(fr, FL);
    latch(fr, also);
  endtask

  task automatic commit();
    model_commit();
    pulse(M_COMMIT);
  endtask

  task automatic err_clr();
    err_m = 0;
    pulse(M_CLR);
  endtask

  task automatic set_run(input logic v);
    run_active = v;
    cycles(4);
    if (!v && pend_m) begin
      pend_m = 0;
      model_commit();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    model_reset();
    cycles(6);
  endtask

  initial begin
    logic [RW-1:0] d;
    int            op, n;
    model_reset();
    last_cap   = '0;
    run_active = 1'b0;
    gpio_in    = '1;

    // Reset with every GPIO line held high.
    cycles(3);
    chk("rst cfg_update", cfg_update, 1'b0);
    chk("rst sdo", sdo, 1'b0);
    check_all("in_reset");
    rst_n = 1'b1;
    cycles(10);
    check_all("release_high");
    gpio_in = $urandom & ~M_USED;
    cycles(6);
    check_all("lines_low");

    frame(mk(0, 0, 32'h5), '0);
    frame(mk(0, 3, 32'hDEADBEEF), '0);
    commit();
    check_all("write_commit");
    chk("ch0r2", word(0, 2), 32'hDEADBEEF);
    chk("ch2r2", word(2, 2), 32'hDEADBEEF);
    chk("ch1r2", word(1, 2), 32'h0);
    chk("one_update", upd_seen, 1);

    send_bits(mk(0, 3, 32'h11111111), 36);
    latch(mk(0, 3, 32'h11111111), '0);
    check_all("short_frame");
    commit();
    check_all("short_not_written");
    err_clr();
    check_all("err_clr");
    frame(mk(0, 9, 32'h22222222), '0);
    check_all("bad_addr");
    chk("bad_addr_err", frame_err, 1'b1);
    send_bits(mk(0, 1, 32'h0), 5);
    latch(mk(0, 1, 32'h0), M_CLR);
    check_all("err_wins_over_clr");
    err_clr();

    frame(mk(0, 5, 32'hA5A5_0F0F), '0);
    set_run(1'b1);
    commit();
    check_all("commit_blocked");
    chk("pend_high", commit_pend, 1'b1);
    commit();
    check_all("commit_absorbed");
    set_run(1'b0);
    check_all("commit_released");

    frame(mk(0, 0, 32'h4), '0);
    frame(mk(1, 3, 32'h0), '0);
    frame(mk(0, 0, 32'h3), '0);
    chk("readback_const", last_cap, {27'h0, 32'hDEADBEEF, 5'h0});
    check_all("readback");

    frame(mk(0, 1, 32'h12345678), M_COMMIT);
    check_all("latch_commit_same");
    chk("ch0r0_same_copy", word(0, 0), 32'h12345678);

    send_bits(mk(0, 2, 32'h77777777), 20);
    do_reset();
    check_all("mid_frame_reset");
    latch(mk(0, 0, 32'h0), '0);
    check_all("post_reset_latch");
    chk("post_reset_err", frame_err, 1'b1);
    err_clr();

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      d  = $urandom;
      case (op)
        0: frame(mk(0, 0, d), '0);
        1, 2: frame(mk(0, AW'($urandom_range(1, NR)), d), '0);
        3: frame(mk(1, AW'($urandom_range(0, NR + 1)), d), '0);
        4: begin
          if ($urandom_range(0, 1) == 1) frame(mk(0, AW'($urandom_range(1, NR)), d), M_COMMIT);
          else commit();
        end
        5: set_run(~run_active);
        6: begin
          if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(1, 36);
            send_bits(mk(0, 1, d), n);
            latch(mk(0, 1, d), ($urandom_range(0, 1) == 1) ? M_CLR : '0);
          end else frame(mk(0, AW'($urandom_range(NR + 1, 15)), d), '0);
        end
        default: err_clr();
      endcase
      check_all($sformatf("rand%0d op%0d", it, op));
    end
    set_run(1'b0);
    frame(mk(0, 0, 32'h1), '0);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    bad++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
